// File: rtl/gb_lcd_pkg.sv
// Shared types and geometry for the Game Boy LCD framebuffer sink.
package gb_lcd_pkg;

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'd0,
    MODE_VBLANK = 2'd1,
    MODE_SCAN   = 2'd2,
    MODE_DRAW   = 2'd3
  } ppu_mode_e;

  typedef enum logic {
    WR_IDLE  = 1'b0,
    WR_WRITE = 1'b1
  } wr_state_e;

  localparam int LCD_W          = 160;
  localparam int LCD_H          = 144;
  localparam int BYTES_PER_LINE = 40;
  localparam int FB_BYTES       = 5760;
  localparam int FIFO_DEPTH     = 8;

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
  } fb_entry_t;

  localparam int ENTRY_W = $bits(fb_entry_t);

  // xb is the pixel column divided by four (byte index within the line).
  function automatic logic [12:0] fb_byte_addr(input logic [7:0] line, input logic [5:0] xb);
    return 13'(line) * 13'(BYTES_PER_LINE) + 13'(xb);
  endfunction

endpackage

// File: rtl/lcd_sink_fifo.sv
// Synchronous FIFO for framebuffer bytes; push while full is dropped unless a
// pop happens on the same edge.
module lcd_sink_fifo
  import gb_lcd_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int W     = ENTRY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] pop_dat_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full_o || do_pop);
  assign pop_dat_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/gb_lcd_sink.sv
// Packs 2-bit PPU pixels four per byte and streams them to a framebuffer via an
// 8-entry FIFO. Define LCD_SINK_PALETTE_EN to shade pixels through bgp first.
module gb_lcd_sink
  import gb_lcd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  px,
  input  logic        px_valid,
  input  logic [1:0]  ppu_mode,
  input  logic        lcd_on,
  input  logic [7:0]  bgp,
  output logic [12:0] fb_addr,
  output logic [7:0]  fb_data,
  output logic        fb_write,
  input  logic        fb_waitrequest,
  output logic [7:0]  line_cnt,
  output logic        frame_done,
  output logic        overflow
);

  ppu_mode_e   mode_q, mode_in;
  logic [7:0]  x_q, x_d, x_n;
  logic [7:0]  line_q, line_d;
  logic [7:0]  pack_q, pack_d, pack_n, pack_px;
  logic        pend_q, pend_d;
  logic        overflow_q, overflow_d;
  logic [1:0]  shade;
  logic        px_take, eol, frame_end;
  logic        push, pop, full, empty;
  fb_entry_t   push_dat, pop_dat;
  wr_state_e   wr_q, wr_d;
  logic [12:0] fb_addr_q, fb_addr_d;
  logic [7:0]  fb_data_q, fb_data_d;

`ifdef LCD_SINK_PALETTE_EN
  assign shade = bgp[{px, 1'b0} +: 2];
`else
  logic unused_bgp;
  assign shade      = px;
  assign unused_bgp = ^bgp;
`endif

  assign mode_in   = ppu_mode_e'(ppu_mode);
  assign eol       = (mode_q == MODE_DRAW) && (mode_in == MODE_HBLANK);
  assign frame_end = (mode_in == MODE_VBLANK) && (mode_q != MODE_VBLANK);
  assign px_take   = px_valid && (x_q < 8'(LCD_W)) && (line_q < 8'(LCD_H));
  assign pack_px   = pack_q | ({shade, 6'b0} >> {x_q[1:0], 1'b0});

  assign frame_done = pend_q && empty && (wr_q == WR_IDLE);
  assign overflow_d = overflow_q | (push && full && !pop);

  // The pixel of this cycle is folded in before any end-of-line flush.
  always_comb begin
    x_d      = x_q;
    line_d   = line_q;
    pack_d   = pack_q;
    pend_d   = pend_q;
    x_n      = x_q;
    pack_n   = pack_q;
    push     = 1'b0;
    push_dat = '0;
    if (!lcd_on) begin
      x_d    = '0;
      line_d = '0;
      pack_d = '0;
      pend_d = 1'b0;
    end else begin
      if (px_take) begin
        x_n    = x_q + 8'd1;
        pack_n = pack_px;
        if (x_q[1:0] == 2'd3) begin
          push     = 1'b1;
          push_dat = '{addr: fb_byte_addr(line_q, x_q[7:2]), data: pack_px};
          pack_n   = '0;
        end
      end
      x_d    = x_n;
      pack_d = pack_n;
      if (frame_done) pend_d = 1'b0;
      if (eol) begin
        if (x_n[1:0] != 2'd0) begin
          push     = 1'b1;
          push_dat = '{addr: fb_byte_addr(line_q, x_n[7:2]), data: pack_n};
        end
        x_d    = '0;
        pack_d = '0;
        if (line_q < 8'(LCD_H)) line_d = line_q + 8'd1;
      end
      if (frame_end) begin
        x_d    = '0;
        line_d = '0;
        pack_d = '0;
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_SCAN;
      x_q        <= '0;
      line_q     <= '0;
      pack_q     <= '0;
      pend_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      mode_q     <= mode_in;
      x_q        <= x_d;
      line_q     <= line_d;
      pack_q     <= pack_d;
      pend_q     <= pend_d;
      overflow_q <= overflow_d;
    end
  end

  lcd_sink_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .pop_dat_o  (pop_dat),
    .full_o     (full),
    .empty_o    (empty)
  );

  always_comb begin
    wr_d      = wr_q;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    pop       = 1'b0;
    case (wr_q)
      WR_IDLE:  if (!empty) pop = 1'b1;
      WR_WRITE: if (!fb_waitrequest) begin
        if (!empty) pop = 1'b1;
        else        wr_d = WR_IDLE;
      end
      default:  wr_d = WR_IDLE;
    endcase
    if (pop) begin
      wr_d      = WR_WRITE;
      fb_addr_d = pop_dat.addr;
      fb_data_d = pop_dat.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q      <= WR_IDLE;
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else begin
      wr_q      <= wr_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
    end
  end

  assign fb_write = (wr_q == WR_WRITE);
  assign fb_addr  = fb_addr_q;
  assign fb_data  = fb_data_q;
  assign line_cnt = line_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_gb_lcd_sink.sv
// Randomized self-checking bench for gb_lcd_sink against a line-level pixel model.
module tb_gb_lcd_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  px;
  logic        px_valid;
  logic [1:0]  ppu_mode;
  logic        lcd_on;
  logic [7:0]  bgp;
  logic [12:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_write;
  logic        fb_waitrequest;
  logic [7:0]  line_cnt;
  logic        frame_done;
  logic        overflow;

  always #5 clk = ~clk;

  gb_lcd_sink dut (
    .clk(clk), .rst(rst), .px(px), .px_valid(px_valid), .ppu_mode(ppu_mode),
    .lcd_on(lcd_on), .bgp(bgp), .fb_addr(fb_addr), .fb_data(fb_data),
    .fb_write(fb_write), .fb_waitrequest(fb_waitrequest), .line_cnt(line_cnt),
    .frame_done(frame_done), .overflow(overflow)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // Observed writes and frame_done pulses, sampled mid-cycle.
  int          act_q[$];
  int          cyc = 0;
  int          last_acc = -1;
  int          fd_cnt = 0;
  int          fd_cyc = -1;
  logic        prev_stall = 1'b0;
  logic [12:0] prev_addr = '0;
  logic [7:0]  prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (fb_write && !fb_waitrequest) begin
        act_q.push_back(int'({fb_addr, fb_data}));
        last_acc = cyc;
      end
      if (prev_stall && fb_write) begin
        chk("stall_addr", int'(fb_addr), int'(prev_addr));
        chk("stall_data", int'(fb_data), int'(prev_data));
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
    end
    prev_stall = fb_write && fb_waitrequest && !rst;
    prev_addr  = fb_addr;
    prev_data  = fb_data;
  end

  // 0: never stall, 1: always stall, 2: random 25% stall
  int wr_mode = 0;
  initial begin
    fb_waitrequest = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (wr_mode)
        0:       fb_waitrequest = 1'b0;
        1:       fb_waitrequest = 1'b1;
        default: fb_waitrequest = ($urandom_range(0, 3) == 0);
      endcase
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: the shaded pixels of the current line and the bytes they must produce.
  int m_line = 0;
  int m_pix[$];
  int exp_q[$];

  function automatic int shade_of(input int p);
`ifdef LCD_SINK_PALETTE_EN
    return (int'(bgp) >> (2 * p)) & 3;
`else
    return p;
`endif
  endfunction

  function automatic void model_px(input int p);
    if (!lcd_on) begin
      m_pix.delete();
      m_line = 0;
    end else if (m_pix.size() < 160 && m_line < 144) begin
      m_pix.push_back(shade_of(p));
    end
  endfunction

  function automatic void model_bytes(input int nbytes);
    for (int b = 0; b < nbytes; b++) begin
      int d = 0;
      for (int k = 0; k < 4; k++)
        if (4 * b + k < m_pix.size()) d |= m_pix[4 * b + k] << (6 - 2 * k);
      exp_q.push_back(((m_line * 40 + b) << 8) | d);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic px_cycle(input int p);
    px       = 2'(p);
    px_valid = 1'b1;
    tick();
    px_valid = 1'b0;
    model_px(p);
  endtask

  task automatic end_line(input bit with_px, input int p);
    ppu_mode = 2'd0;
    px       = 2'(p);
    px_valid = with_px;
    tick();
    px_valid = 1'b0;
    if (with_px) model_px(p);
    if (!lcd_on) begin
      m_pix.delete();
      m_line = 0;
    end else begin
      if (m_line < 144) model_bytes((m_pix.size() + 3) / 4);
      if (m_line < 144) m_line++;
      m_pix.delete();
    end
    ppu_mode = 2'd2;
    tick();
    ppu_mode = 2'd3;
    tick();
  endtask

  task automatic end_frame();
    ppu_mode = 2'd1;
    tick();
    if (m_line < 144) model_bytes(m_pix.size() / 4);
    m_line = 0;
    m_pix.delete();
    ppu_mode = 2'd2;
    tick();
  endtask

  task automatic drain();
    int quiet = 0;
    for (int i = 0; i < 3000 && quiet < 4; i++) begin
      tick();
      quiet = fb_write ? 0 : quiet + 1;
    end
    chk("drain_quiet", quiet, 4);
  endtask

  task automatic compare_writes(input string tag);
    int nbad  = 0;
    int first = -1;
    chk({tag, "_count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      if (act_q[i] != exp_q[i]) begin
        nbad++;
        if (first < 0) first = i;
      end
    chk({tag, "_bad_bytes"}, nbad, 0);
    if (first >= 0) chk({tag, "_first_bad"}, act_q[first], exp_q[first]);
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    wr_mode  = 0;
    ppu_mode = 2'd2;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    m_line   = 0;
    m_pix.delete();
    exp_q.delete();
    act_q.delete();
    fd_cnt   = 0;
  endtask

  initial begin
    int n;
    rst = 1'b1; px = '0; px_valid = 1'b0; ppu_mode = 2'd2; lcd_on = 1'b1; bgp = 8'hE4;
    repeat (2) tick();
    chk("rst_fb_write", int'(fb_write), 0);
    chk("rst_fb_addr", int'(fb_addr), 0);
    chk("rst_fb_data", int'(fb_data), 0);
    chk("rst_line_cnt", int'(line_cnt), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_overflow", int'(overflow), 0);
    rst = 1'b0;

    // Single byte latency and pulse width.
    ppu_mode = 2'd3;
    tick();
    px_cycle(3); px_cycle(2); px_cycle(1); px_cycle(0);
    chk("first_wr_not_early", int'(fb_write), 0);
    tick();
    chk("first_wr_high", int'(fb_write), 1);
    chk("first_wr_addr", int'(fb_addr), 0);
    chk("first_wr_data", int'(fb_data), 'hE4);
    tick();
    chk("first_wr_one_cycle", int'(fb_write), 0);

    // Palette mapping of px 0 through bgp=0x1B.
    bgp = 8'h1B;
    repeat (4) px_cycle(0);
    drain();
    chk("pal_count", act_q.size(), 2);
    if (act_q.size() >= 2) begin
`ifdef LCD_SINK_PALETTE_EN
      chk("pal_byte", act_q[1], (1 << 8) | 'hFF);
`else
      chk("pal_byte", act_q[1], (1 << 8) | 'h00);
`endif
    end
    bgp = 8'hE4;
    do_reset();

    // Partial byte flush at end of line.
    ppu_mode = 2'd3;
    tick();
    repeat (6) px_cycle(1);
    end_line(1'b0, 0);
    drain();
    chk("flush_count", act_q.size(), 2);
    if (act_q.size() >= 2) begin
      chk("flush_b0", act_q[0], 'h055);
      chk("flush_b1", act_q[1], 'h150);
    end
    chk("flush_line_cnt", int'(line_cnt), 1);
    do_reset();

    // LCD off discards the partial byte and keeps the line counter at 0.
    ppu_mode = 2'd3;
    tick();
    repeat (3) px_cycle(3);
    lcd_on = 1'b0;
    repeat (8) px_cycle(2);
    end_line(1'b1, 1);
    lcd_on = 1'b1;
    drain();
    compare_writes("lcdoff");
    chk("lcdoff_line_cnt", int'(line_cnt), 0);
    do_reset();

    // Random lines with gaps, overlong lines, random stalls and a random palette.
    bgp = 8'($urandom);
    ppu_mode = 2'd3;
    tick();
    wr_mode = 2;
    for (int l = 0; l < 6; l++) begin
      n = $urandom_range(0, 170);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          px = 2'($urandom);
          tick();
        end else begin
          px_cycle($urandom_range(0, 3));
        end
      end
      end_line(1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
    chk("rand_line_cnt", int'(line_cnt), m_line);
    n = $urandom_range(1, 30);
    for (int i = 0; i < n; i++) px_cycle($urandom_range(0, 3));
    end_frame();
    wr_mode = 0;
    drain();
    compare_writes("rand");
    chk("rand_frame_line_cnt", int'(line_cnt), 0);
    chk("rand_frame_done_cnt", fd_cnt, 1);
    bgp = 8'hE4;
    do_reset();

    // Overflow under a 60-cycle stall; flag is sticky until reset.
    ppu_mode = 2'd3;
    tick();
    wr_mode = 1;
    for (int i = 0; i < 160; i++) begin
      if (i == 60) begin
        chk("ovf_set", int'(overflow), 1);
        wr_mode = 0;
      end
      px_cycle(i % 4);
    end
    end_line(1'b0, 0);
    drain();
    chk("ovf_sticky", int'(overflow), 1);
    chk("ovf_bytes_dropped", int'(act_q.size() < 40), 1);
    do_reset();
    chk("ovf_cleared_by_rst", int'(overflow), 0);

    // Reset during a stalled write with a full FIFO.
    ppu_mode = 2'd3;
    tick();
    end_line(1'b0, 0);
    wr_mode = 1;
    repeat (40) px_cycle(1);
    tick();
    chk("rstw_pre_write", int'(fb_write), 1);
    chk("rstw_pre_ovf", int'(overflow), 1);
    chk("rstw_pre_line", int'(line_cnt), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw_fb_write", int'(fb_write), 0);
    chk("rstw_overflow", int'(overflow), 0);
    chk("rstw_line_cnt", int'(line_cnt), 0);
    wr_mode = 0;
    act_q.delete();
    repeat (10) tick();
    chk("rstw_fifo_empty", act_q.size(), 0);
    do_reset();

    // Full frame of px=2.
    ppu_mode = 2'd3;
    tick();
    for (int l = 0; l < 144; l++) begin
      for (int i = 0; i < 160; i++) px_cycle(2);
      end_line(1'b0, 0);
    end
    chk("frame_line_sat", int'(line_cnt), 144);
    end_frame();
    drain();
    chk("frame_writes", act_q.size(), 5760);
    if (act_q.size() > 0) chk("frame_last", act_q[act_q.size() - 1], (5759 << 8) | 'hAA);
    chk("frame_done_cnt", fd_cnt, 1);
    chk("frame_done_after_last", int'(fd_cyc > last_acc), 1);
    chk("frame_line_cnt", int'(line_cnt), 0);
    compare_writes("frame");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
